// File: rtl/four_bit_signed_multiplier_if.sv
`default_nettype none
// ============================================================================
// Module      : four_bit_signed_multiplier_if
// Description : Operand/result bundle for the 4x4 signed multiplier. The
//               master drives the operands and the capture strobe; the
//               slave (the multiplier) returns the registered product.
// Revision    : 1.0 - initial release
// ============================================================================
interface four_bit_signed_multiplier_if;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic [7:0] product;
  logic       out_valid;

  modport master (
    output in_valid,
    output a,
    output b,
    input  product,
    input  out_valid
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    output product,
    output out_valid
  );
endinterface
`default_nettype wire

// File: rtl/four_bit_signed_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : four_bit_signed_multiplier
// Description : Registered 4x4 two's-complement multiplier with an exact
//               8-bit signed product and one cycle of latency. The product
//               is built from a Baugh-Wooley partial-product array summed
//               by explicit half/full-adder ripple rows.
// Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// Half adder cell
// ----------------------------------------------------------------------------
module four_bit_signed_multiplier_ha (
  input  wire logic x,
  input  wire logic y,
  output logic      s,
  output logic      co
);
  assign s  = x ^ y;
  assign co = x & y;
endmodule

// ----------------------------------------------------------------------------
// Full adder cell
// ----------------------------------------------------------------------------
module four_bit_signed_multiplier_fa (
  input  wire logic x,
  input  wire logic y,
  input  wire logic ci,
  output logic      s,
  output logic      co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));
endmodule

// ----------------------------------------------------------------------------
// 8-bit ripple adder, modulo 2^8. The carry out of the top bit is never
// needed because the final product is truncated to 8 bits, so bit 7 is a
// bare XOR rather than a full adder.
// ----------------------------------------------------------------------------
module four_bit_signed_multiplier_rca8 (
  input  wire logic [7:0] x,
  input  wire logic [7:0] y,
  output logic      [7:0] s
);
  logic [7:1] w_c;

  four_bit_signed_multiplier_ha u_ha0 (
    .x  (x[0]),
    .y  (y[0]),
    .s  (s[0]),
    .co (w_c[1])
  );

  for (genvar k = 1; k < 7; k++) begin : g_fa
    four_bit_signed_multiplier_fa u_fa (
      .x  (x[k]),
      .y  (y[k]),
      .ci (w_c[k]),
      .s  (s[k]),
      .co (w_c[k+1])
    );
  end

  assign s[7] = x[7] ^ y[7] ^ w_c[7];
endmodule

// ----------------------------------------------------------------------------
// Top: partial-product array, adder rows and output register
// ----------------------------------------------------------------------------
module four_bit_signed_multiplier (
  input  wire logic                     clk,
  input  wire logic                     rst_n,
  four_bit_signed_multiplier_if.slave   bus
);
  // Baugh-Wooley correction for n=4: +2^n and +2^(2n-1), i.e. bits 4 and 7.
  localparam logic [7:0] c_BW_CORR = 8'h90;

  // w_pp[j][i] is the (possibly inverted) term a[i]&b[j], weight 2^(i+j).
  logic [3:0][3:0] w_pp;
  // w_row[j] is partial-product row j aligned to its weight.
  logic [3:0][7:0] w_row;
  logic [7:0]      w_sum01;
  logic [7:0]      w_sum012;
  logic [7:0]      w_sum0123;
  logic [7:0]      w_product;

  logic [7:0]      r_product;
  logic            r_out_valid;

  // Terms that pair exactly one sign bit with a magnitude bit carry negative
  // weight; inverting them (plus the correction constant) keeps every row
  // non-negative so plain unsigned adders can sum the array.
  for (genvar j = 0; j < 4; j++) begin : g_pp_row
    for (genvar i = 0; i < 4; i++) begin : g_pp_col
      if ((i == 3) != (j == 3)) begin : g_inv
        assign w_pp[j][i] = ~(bus.a[i] & bus.b[j]);
      end else begin : g_plain
        assign w_pp[j][i] = bus.a[i] & bus.b[j];
      end
    end
  end

  // Shift each row into position; bits outside the row's span are zero.
  for (genvar j = 0; j < 4; j++) begin : g_row
    for (genvar k = 0; k < 8; k++) begin : g_bit
      if ((k >= j) && (k < j + 4)) begin : g_term
        assign w_row[j][k] = w_pp[j][k-j];
      end else begin : g_zero
        assign w_row[j][k] = 1'b0;
      end
    end
  end

  four_bit_signed_multiplier_rca8 u_add01 (
    .x (w_row[0]),
    .y (w_row[1]),
    .s (w_sum01)
  );

  four_bit_signed_multiplier_rca8 u_add012 (
    .x (w_sum01),
    .y (w_row[2]),
    .s (w_sum012)
  );

  four_bit_signed_multiplier_rca8 u_add0123 (
    .x (w_sum012),
    .y (w_row[3]),
    .s (w_sum0123)
  );

  four_bit_signed_multiplier_rca8 u_add_corr (
    .x (w_sum0123),
    .y (c_BW_CORR),
    .s (w_product)
  );

  // Capture the product on a valid strobe; the result holds otherwise while
  // out_valid marks only the cycle right after a capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_product   <= 8'h00;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_product <= w_product;
      end
    end
  end

  assign bus.product   = r_product;
  assign bus.out_valid = r_out_valid;
endmodule
`default_nettype wire

// File: tb/tb_four_bit_signed_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : tb_four_bit_signed_multiplier
// Description : Self-checking bench for the registered 4x4 signed multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_four_bit_signed_multiplier;
  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  four_bit_signed_multiplier_if bus ();

  four_bit_signed_multiplier dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: signed integer product, truncated to 8 bits.
  function automatic logic [7:0] ref_mul(input logic [3:0] x, input logic [3:0] y);
    int sx;
    int sy;
    int p;
    sx = $signed(x);
    sy = $signed(y);
    p  = sx * sy;
    return p[7:0];
  endfunction

  // Present operands on the falling edge, then wait until just after the
  // next rising edge so outputs are sampled away from the clock.
  task automatic drive(input logic v, input logic [3:0] x, input logic [3:0] y);
    @(negedge clk);
    bus.in_valid = v;
    bus.a        = x;
    bus.b        = y;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.a        = 4'd0;
    bus.b        = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (bus.product !== 8'h00 || bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_initial: product=%h out_valid=%b, expected 00/0", bus.product, bus.out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // Produce 35, then pull reset between clock edges.
    drive(1'b1, 4'd7, 4'd5);
    tests++;
    if (bus.product !== 8'h23) begin
      fails++;
      $display("FAIL reset_preload: product=%h expected 23", bus.product);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (bus.product !== 8'h00 || bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_async: product=%h out_valid=%b, expected 00/0", bus.product, bus.out_valid);
    end
    // Held through a clock edge even with a valid operand pair pending.
    bus.in_valid = 1'b1;
    bus.a        = 4'd3;
    bus.b        = 4'd3;
    @(posedge clk);
    #1;
    tests++;
    if (bus.product !== 8'h00 || bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_hold: product=%h out_valid=%b, expected 00/0", bus.product, bus.out_valid);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;
  endtask

  task automatic test_directed();
    logic [3:0] ta [10];
    logic [3:0] tb [10];
    logic [7:0] te [10];
    ta = '{4'd0, 4'd3, 4'd7, 4'd0, 4'd1,    4'b1111, 4'b1000, 4'b1000, 4'd7,    4'b1111};
    tb = '{4'd0, 4'd2, 4'd5, 4'd5, 4'b1010, 4'b1111, 4'b1000, 4'd7,    4'b1000, 4'b1000};
    te = '{8'h00, 8'h06, 8'h23, 8'h00, 8'hFA, 8'h01, 8'h40, 8'hC8, 8'hC8, 8'h08};
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, ta[i], tb[i]);
      tests++;
      if (bus.product !== te[i] || bus.out_valid !== 1'b1) begin
        fails++;
        $display("FAIL directed[%0d] a=%h b=%h: product=%h out_valid=%b, expected %h/1",
                 i, ta[i], tb[i], bus.product, bus.out_valid, te[i]);
      end
    end
  endtask

  task automatic test_hold();
    drive(1'b1, 4'd3, 4'd2);
    tests++;
    if (bus.product !== 8'h06 || bus.out_valid !== 1'b1) begin
      fails++;
      $display("FAIL hold_load: product=%h out_valid=%b, expected 06/1", bus.product, bus.out_valid);
    end
    drive(1'b0, 4'd7, 4'd7);
    tests++;
    if (bus.product !== 8'h06 || bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL hold_idle: product=%h out_valid=%b, expected 06/0", bus.product, bus.out_valid);
    end
  endtask

  task automatic test_exhaustive();
    logic [3:0] x;
    logic [3:0] y;
    for (int i = 0; i < 256; i++) begin
      x = i[7:4];
      y = i[3:0];
      drive(1'b1, x, y);
      tests++;
      if (bus.product !== ref_mul(x, y) || bus.out_valid !== 1'b1) begin
        fails++;
        $display("FAIL exhaustive a=%h b=%h: product=%h out_valid=%b, expected %h/1",
                 x, y, bus.product, bus.out_valid, ref_mul(x, y));
      end
    end
  endtask

  // Random strobes and operands; the model remembers the last captured result.
  task automatic test_random();
    logic [3:0] x;
    logic [3:0] y;
    logic       v;
    logic [7:0] held;
    held = bus.product;
    for (int i = 0; i < 200; i++) begin
      x = 4'($urandom);
      y = 4'($urandom);
      v = ($urandom_range(0, 3) != 0);
      if (v) held = ref_mul(x, y);
      drive(v, x, y);
      tests++;
      if (bus.product !== held || bus.out_valid !== v) begin
        fails++;
        $display("FAIL random[%0d] v=%b a=%h b=%h: product=%h out_valid=%b, expected %h/%b",
                 i, v, x, y, bus.product, bus.out_valid, held, v);
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_directed();
    test_hold();
    test_exhaustive();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
